// File: rtl/pad_drive_sequencer.sv
// Direction sequencer for one bidirectional pad: turnaround-gapped OEN/I control plus O synchroniser.
// Optional drive/readback contention detector enabled by defining PAD_DRIVE_SEQ_CONTENTION_CHECK_EN.
module pad_drive_sequencer #(
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2,
    parameter int OPEN_DRAIN  = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    output logic req_ready_o,
    input  logic req_dir_i,
    input  logic req_data_i,
    output logic pad_oen_o,
    output logic pad_i_o,
    input  logic pad_o_i,
    output logic rd_data_o,
    output logic busy_o,
    output logic contention_o
);

    // state    | meaning
    // RX       | pad released, sampling only
    // TURN_OUT | gap before driving, OEN=1
    // TX       | pad driven from data_q
    // TURN_IN  | gap after driving, OEN=1
    typedef enum logic [1:0] {RX, TURN_OUT, TX, TURN_IN} state_t;

    localparam int CW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam bit OD = (OPEN_DRAIN != 0);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   data_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hs;

    assign hs        = req_valid_i & req_ready_o;
    assign pad_i_o   = OD ? 1'b0 : data_q;
    assign rd_data_o = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RX;
            cnt         <= '0;
            data_q      <= 1'b0;
            pad_oen_o   <= 1'b1;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                RX: begin
                    if (hs && req_dir_i) begin
                        data_q <= req_data_i;
                        if (TURN_CYCLES == 0) begin
                            state     <= TX;
                            pad_oen_o <= OD ? req_data_i : 1'b0;
                        end else begin
                            state       <= TURN_OUT;
                            cnt         <= CNT_LOAD;
                            busy_o      <= 1'b1;
                            req_ready_o <= 1'b0;
                        end
                    end
                end
                TURN_OUT: begin
                    if (cnt == '0) begin
                        state       <= TX;
                        pad_oen_o   <= OD ? data_q : 1'b0;
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX: begin
                    if (hs) begin
                        if (req_dir_i) begin
                            data_q    <= req_data_i;
                            pad_oen_o <= OD ? req_data_i : 1'b0;
                        end else begin
                            pad_oen_o <= 1'b1;
                            if (TURN_CYCLES == 0) begin
                                state <= RX;
                            end else begin
                                state       <= TURN_IN;
                                cnt         <= CNT_LOAD;
                                busy_o      <= 1'b1;
                                req_ready_o <= 1'b0;
                            end
                        end
                    end
                end
                TURN_IN: begin
                    if (cnt == '0) begin
                        state       <= RX;
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= RX;
                    pad_oen_o   <= 1'b1;
                    busy_o      <= 1'b0;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pad_o_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef PAD_DRIVE_SEQ_CONTENTION_CHECK_EN
    // Compare only after the driven value has propagated through the synchroniser.
    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    logic [SW-1:0] settle;
    logic          contention_q;
    logic          mismatch;

    always_comb begin
        mismatch = OD ? (!data_q && rd_data_o) : (rd_data_o != data_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle       <= '0;
            contention_q <= 1'b0;
        end else if (hs) begin
            settle       <= '0;
            contention_q <= 1'b0;
        end else if (state != TX) begin
            settle <= '0;
        end else if (settle != SW'(SETTLE)) begin
            settle <= settle + 1'b1;
        end else if (mismatch) begin
            contention_q <= 1'b1;
        end
    end

    assign contention_o = contention_q;
`else
    assign contention_o = 1'b0;
`endif

endmodule

// File: tb/tb_pad_drive_sequencer.sv
// Directed bench: push-pull instance (TURN_CYCLES=2) and open-drain instance (TURN_CYCLES=0).
module tb_pad_drive_sequencer;

    logic clk_i = 1'b0;
    logic rst_i;

    logic pp_valid, pp_dir, pp_data, pp_pad_o;
    logic pp_ready, pp_oen, pp_pad_i, pp_rd, pp_busy, pp_cont;

    logic od_valid, od_dir, od_data, od_pad_o;
    logic od_ready, od_oen, od_pad_i, od_rd, od_busy, od_cont;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pad_drive_sequencer #(.TURN_CYCLES(2), .SYNC_STAGES(2), .OPEN_DRAIN(0)) u_pp (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(pp_valid), .req_ready_o(pp_ready),
        .req_dir_i(pp_dir), .req_data_i(pp_data),
        .pad_oen_o(pp_oen), .pad_i_o(pp_pad_i), .pad_o_i(pp_pad_o),
        .rd_data_o(pp_rd), .busy_o(pp_busy), .contention_o(pp_cont)
    );

    pad_drive_sequencer #(.TURN_CYCLES(0), .SYNC_STAGES(2), .OPEN_DRAIN(1)) u_od (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(od_valid), .req_ready_o(od_ready),
        .req_dir_i(od_dir), .req_data_i(od_data),
        .pad_oen_o(od_oen), .pad_i_o(od_pad_i), .pad_o_i(od_pad_o),
        .rd_data_o(od_rd), .busy_o(od_busy), .contention_o(od_cont)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        pp_valid = 1'b1; pp_dir = 1'b1; pp_data = 1'b1; pp_pad_o = 1'b0;
        od_valid = 1'b1; od_dir = 1'b1; od_data = 1'b0; od_pad_o = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({pp_oen, pp_pad_i, pp_ready, pp_busy, pp_rd, pp_cont} !== 6'b101000) begin
                failures++;
                $display("FAIL reset_pp cycle %0d: oen/i/ready/busy/rd/cont=%b expected 101000", c,
                         {pp_oen, pp_pad_i, pp_ready, pp_busy, pp_rd, pp_cont});
            end
            checks++;
            if ({od_oen, od_pad_i, od_ready, od_busy, od_rd, od_cont} !== 6'b101000) begin
                failures++;
                $display("FAIL reset_od cycle %0d: oen/i/ready/busy/rd/cont=%b expected 101000", c,
                         {od_oen, od_pad_i, od_ready, od_busy, od_rd, od_cont});
            end
        end
        rst_i = 1'b0;
        pp_valid = 1'b0;
        od_valid = 1'b0;
    endtask

    task automatic test_turn_out();
        logic [2:0] exp_obr [1:3];
        exp_obr[1] = 3'b110; exp_obr[2] = 3'b110; exp_obr[3] = 3'b001;
        step();
        pp_valid = 1'b1; pp_dir = 1'b1; pp_data = 1'b1;
        step();
        pp_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({pp_oen, pp_busy, pp_ready} !== exp_obr[c]) begin
                failures++;
                $display("FAIL turn_out cycle %0d: oen/busy/ready=%b expected %b", c,
                         {pp_oen, pp_busy, pp_ready}, exp_obr[c]);
            end
            if (c < 3) step();
        end
        checks++;
        if (pp_pad_i !== 1'b1) begin
            failures++;
            $display("FAIL turn_out_data: pad_i=%b expected 1", pp_pad_i);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] vals;
        vals = 2'b10;
        pp_valid = 1'b1; pp_dir = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pp_data = vals[k];
            step();
            checks++;
            if ({pp_pad_i, pp_oen, pp_ready} !== {vals[k], 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL back_to_back %0d: pad_i/oen/ready=%b expected %b", k,
                         {pp_pad_i, pp_oen, pp_ready}, {vals[k], 1'b0, 1'b1});
            end
        end
        pp_valid = 1'b0;
    endtask

    task automatic test_contention();
`ifdef PAD_DRIVE_SEQ_CONTENTION_CHECK_EN
        bit seen;
        seen = 1'b0;
        pp_pad_o = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (pp_cont === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL contention_set: contention=%b expected 1 within 10 cycles", pp_cont);
        end
        pp_pad_o = 1'b1;
        pp_valid = 1'b1; pp_dir = 1'b1; pp_data = 1'b1;
        step();
        pp_valid = 1'b0;
        checks++;
        if (pp_cont !== 1'b0) begin
            failures++;
            $display("FAIL contention_clear: contention=%b expected 0", pp_cont);
        end
`else
        pp_pad_o = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (pp_cont !== 1'b0) begin
                failures++;
                $display("FAIL contention_tied cycle %0d: contention=%b expected 0", c, pp_cont);
            end
        end
`endif
    endtask

    task automatic test_sync();
        pp_pad_o = 1'b0;
        step(); step(); step();
        pp_pad_o = 1'b1;
        step();
        checks++;
        if (pp_rd !== 1'b0) begin
            failures++;
            $display("FAIL sync_lat1: rd_data=%b expected 0", pp_rd);
        end
        step();
        checks++;
        if (pp_rd !== 1'b1) begin
            failures++;
            $display("FAIL sync_lat2: rd_data=%b expected 1", pp_rd);
        end
    endtask

    task automatic test_turn_in();
        logic [2:0] exp_obr [1:3];
        exp_obr[1] = 3'b110; exp_obr[2] = 3'b110; exp_obr[3] = 3'b101;
        pp_valid = 1'b1; pp_dir = 1'b0; pp_data = 1'b1;
        step();
        pp_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({pp_oen, pp_busy, pp_ready} !== exp_obr[c]) begin
                failures++;
                $display("FAIL turn_in cycle %0d: oen/busy/ready=%b expected %b", c,
                         {pp_oen, pp_busy, pp_ready}, exp_obr[c]);
            end
            if (c < 3) step();
        end
        pp_valid = 1'b1; pp_dir = 1'b0;
        step();
        pp_valid = 1'b0;
        step();
        checks++;
        if ({pp_oen, pp_busy, pp_ready} !== 3'b101) begin
            failures++;
            $display("FAIL rx_release_noop: oen/busy/ready=%b expected 101",
                     {pp_oen, pp_busy, pp_ready});
        end
    endtask

    task automatic test_open_drain();
        logic [2:0] dirs;
        logic [2:0] datas;
        logic [2:0] exp_oen;
        dirs = 3'b011; datas = 3'b001; exp_oen = 3'b101;
        od_pad_o = 1'b0;
        for (int k = 0; k < 3; k++) begin
            od_valid = 1'b1; od_dir = dirs[k]; od_data = datas[k];
            step();
            od_valid = 1'b0;
            checks++;
            if ({od_oen, od_pad_i, od_busy, od_ready} !== {exp_oen[k], 3'b001}) begin
                failures++;
                $display("FAIL open_drain step %0d: oen/i/busy/ready=%b expected %b", k,
                         {od_oen, od_pad_i, od_busy, od_ready}, {exp_oen[k], 3'b001});
            end
        end
        step();
        checks++;
        if ({od_oen, od_cont} !== 2'b10) begin
            failures++;
            $display("FAIL open_drain_rx: oen/cont=%b expected 10", {od_oen, od_cont});
        end
    endtask

    initial begin
        test_reset();
        test_turn_out();
        test_back_to_back();
        test_contention();
        test_sync();
        test_turn_in();
        test_open_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
